// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only, one-word-per-line cache between the load path and DataMemory.
// Hits are answered from local tag/data arrays; misses read the registered memory port and fill the line.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [1:0]        state_dbg
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2
  } state_t;

  // Handshake: req/flush are only sampled at an edge where ready=1; flush wins over req.
  // rsp_valid is a one-cycle pulse, rsp_data/rsp_hit hold until the next response.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_hit_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    addr_tag;
  logic                line_hit;
  logic                accept;
  logic                do_flush;
  logic                hit_done;
  logic                fill_done;

  assign idx      = addr_q[INDEX_W-1:0];
  assign addr_tag = addr_q[ADDR_W-1:INDEX_W];
  assign line_hit = valid_q[idx] && (tag_mem[idx] == addr_tag);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    do_flush  = 1'b0;
    hit_done  = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          do_flush = 1'b1;
        end else if (req) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (line_hit) begin
          hit_done = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= hit_done || fill_done;
      if (accept) addr_q <= req_addr;
      if (do_flush) begin
        valid_q <= '0;
      end else if (fill_done) begin
        valid_q[idx] <= 1'b1;
      end
      if (hit_done) begin
        rsp_data_q <= data_mem[idx];
        rsp_hit_q  <= 1'b1;
        if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (fill_done) begin
        rsp_data_q <= mem_data;
        rsp_hit_q  <= 1'b0;
        if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Tag/data payload needs no reset: valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx]  <= addr_tag;
      data_mem[idx] <= mem_data;
    end
  end

  assign ready      = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_hit    = rsp_hit_q;
  assign mem_addr   = addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state_dbg  = state_q;

endmodule
